// File: rtl/mm_arith_pkg.sv
// Shared arithmetic package: FSM state encoding and elaboration helpers
// for the chunked wide arithmetic datapath.
package mm_arith_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sub_state_t;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/chunk_sub_borrow.sv
// One CHUNK-bit slice of the wide subtractor: {bout, diff} = a - b - bin.
module chunk_sub_borrow #(
  parameter int CHUNK = 32
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             bin_i,
  output logic [CHUNK-1:0] diff_o,
  output logic             bout_o
);

  logic [CHUNK:0] full;

  // The extra top bit of the widened difference is exactly the borrow out.
  assign full   = {1'b0, a_i} - {1'b0, b_i} - {{CHUNK{1'b0}}, bin_i};
  assign diff_o = full[CHUNK-1:0];
  assign bout_o = full[CHUNK];

endmodule

// File: rtl/chunked_wide_sub.sv
// Multi-cycle wide subtractor d = a - b, one CHUNK-bit slice per clock with a
// registered borrow between slices; valid/ready handshake on both sides.
module chunked_wide_sub
  import mm_arith_pkg::*;
#(
  parameter int WIDTH = 89,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   d
);

  localparam int NCHUNK = ceil_div(WIDTH, CHUNK);
  localparam int PAD_W  = NCHUNK * CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
    $error("chunked_wide_sub: CHUNK must lie in [1, WIDTH]");
  end

  sub_state_t       state_q, state_d;
  logic [PAD_W-1:0] a_q, a_d;
  logic [PAD_W-1:0] b_q, b_d;
  logic [PAD_W-1:0] res_q, res_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic             sign_q, sign_d;

  int               base;
  logic [CHUNK-1:0] a_sl, b_sl, diff;
  logic             bout;

  // Operands are zero-extended to a whole number of slices, so the top slice
  // needs no special casing in the datapath.
  assign base = int'(idx_q) * CHUNK;
  assign a_sl = a_q[base +: CHUNK];
  assign b_sl = b_q[base +: CHUNK];

  chunk_sub_borrow #(.CHUNK(CHUNK)) u_slice (
    .a_i    (a_sl),
    .b_i    (b_sl),
    .bin_i  (borrow_q),
    .diff_o (diff),
    .bout_o (bout)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    sign_d   = sign_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = PAD_W'(a);
          b_d      = PAD_W'(b);
          idx_d    = '0;
          borrow_d = 1'b0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        res_d[base +: CHUNK] = diff;
        borrow_d             = bout;
        idx_d                = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          sign_d  = bout;
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      sign_q   <= sign_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign d         = {sign_q, res_q[WIDTH-1:0]};

  // Padding bits above WIDTH in the top slice never reach the output.
  if (PAD_W > WIDTH) begin : g_pad_sink
    logic unused_pad;
    assign unused_pad = ^res_q[PAD_W-1:WIDTH];
  end

endmodule

// File: tb/tb_chunked_wide_sub.sv
// Directed and scoreboarded bench for chunked_wide_sub at WIDTH=2/CHUNK=1
// and WIDTH=89/CHUNK=32.
module tb_chunked_wide_sub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Narrow instance: WIDTH=2, CHUNK=1 (NCHUNK=2)
  logic       n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [1:0] n_a, n_b;
  logic [2:0] n_d;

  // Wide instance: WIDTH=89, CHUNK=32 (NCHUNK=3)
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [88:0] w_a, w_b;
  logic [89:0] w_d;

  chunked_wide_sub #(.WIDTH(2), .CHUNK(1)) u_narrow (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (n_in_valid),
    .in_ready  (n_in_ready),
    .a         (n_a),
    .b         (n_b),
    .out_valid (n_out_valid),
    .out_ready (n_out_ready),
    .d         (n_d)
  );

  chunked_wide_sub #(.WIDTH(89), .CHUNK(32)) u_wide (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .a         (w_a),
    .b         (w_b),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .d         (w_d)
  );

  task automatic n_xact(input logic [1:0] a, input logic [1:0] b,
                        output logic [2:0] d_out, output int lat, output bit ok);
    int g = 0;
    while (n_in_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    n_a = a; n_b = b; n_in_valid = 1'b1;
    @(negedge clk);
    n_in_valid = 1'b0; n_a = 'x; n_b = 'x;
    lat = 0;
    while (n_out_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    ok = (n_out_valid === 1'b1);
    d_out = n_d;
    @(negedge clk);
  endtask

  task automatic w_xact(input logic [88:0] a, input logic [88:0] b, input bit consume,
                        output logic [89:0] d_out, output int lat, output bit ok);
    int g = 0;
    while (w_in_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    w_a = a; w_b = b; w_in_valid = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b0; w_a = 'x; w_b = 'x;
    lat = 0;
    while (w_out_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    ok = (w_out_valid === 1'b1);
    d_out = w_d;
    if (consume) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    n_in_valid = 1'b0; n_a = '0; n_b = '0; n_out_ready = 1'b1;
    w_in_valid = 1'b0; w_a = '0; w_b = '0; w_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({n_in_ready, n_out_valid, n_d} !== 5'b1_0_000) begin
      tests_failed++;
      $display("FAIL reset_narrow: got ready/valid/d=%b expected 10000", {n_in_ready, n_out_valid, n_d});
    end
    tests_run++;
    if ({w_in_ready, w_out_valid} !== 2'b10 || w_d !== 90'd0) begin
      tests_failed++;
      $display("FAIL reset_wide: got ready=%b valid=%b d=%h expected ready=1 valid=0 d=0", w_in_ready, w_out_valid, w_d);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_narrow();
    logic [2:0] d_out, exp;
    int lat;
    bit ok;
    n_xact(2'd1, 2'd1, d_out, lat, ok);
    tests_run++;
    if (!ok || d_out !== 3'b000) begin
      tests_failed++;
      $display("FAIL t1_value: got %b expected 000", d_out);
    end
    tests_run++;
    if (lat != 2) begin
      tests_failed++;
      $display("FAIL t1_latency: got %0d expected 2", lat);
    end
    n_xact(2'd1, 2'd2, d_out, lat, ok);
    tests_run++;
    if (!ok || d_out !== 3'b111) begin
      tests_failed++;
      $display("FAIL t2_value: got %b expected 111", d_out);
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        exp = 3'(i) - 3'(j);
        n_xact(2'(i), 2'(j), d_out, lat, ok);
        tests_run++;
        if (!ok || d_out !== exp) begin
          tests_failed++;
          $display("FAIL narrow_%0d_minus_%0d: got %b expected %b", i, j, d_out, exp);
        end
      end
    end
  endtask

  task automatic test_wide();
    logic [89:0] d_out;
    logic [88:0] ones;
    int lat;
    bit ok;
    ones = '1;
    w_xact(89'd1 << 64, 89'd1, 1'b1, d_out, lat, ok);
    tests_run++;
    if (!ok || d_out !== {26'd0, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      tests_failed++;
      $display("FAIL t3_value: got %h expected 2^64-1", d_out);
    end
    tests_run++;
    if (lat != 3) begin
      tests_failed++;
      $display("FAIL t3_latency: got %0d expected 3", lat);
    end
    w_xact(89'd0, ones, 1'b1, d_out, lat, ok);
    tests_run++;
    if (!ok || d_out !== {1'b1, 87'd0, 2'b01}) begin
      tests_failed++;
      $display("FAIL t4_value: got %h expected 2^89+1", d_out);
    end
    w_xact(ones, ones, 1'b1, d_out, lat, ok);
    tests_run++;
    if (!ok || d_out !== 90'd0) begin
      tests_failed++;
      $display("FAIL max_minus_max: got %h expected 0", d_out);
    end
    w_xact(ones, 89'd0, 1'b1, d_out, lat, ok);
    tests_run++;
    if (!ok || d_out !== {1'b0, ones}) begin
      tests_failed++;
      $display("FAIL max_minus_zero: got %h expected 2^89-1", d_out);
    end
    w_xact(89'd0, 89'd1, 1'b1, d_out, lat, ok);
    tests_run++;
    if (!ok || d_out !== {90{1'b1}}) begin
      tests_failed++;
      $display("FAIL zero_minus_one: got %h expected all ones", d_out);
    end
    w_xact(89'h0_0000_0001_0000_0000, 89'd1, 1'b1, d_out, lat, ok);
    tests_run++;
    if (!ok || d_out !== 90'h0_0000_0000_FFFF_FFFF) begin
      tests_failed++;
      $display("FAIL borrow_one_boundary: got %h expected ffffffff", d_out);
    end
  endtask

  task automatic test_backpressure();
    logic [89:0] d_out, held;
    int lat;
    bit ok;
    w_out_ready = 1'b0;
    w_xact(89'd100, 89'd7, 1'b0, d_out, lat, ok);
    tests_run++;
    if (!ok || d_out !== 90'd93) begin
      tests_failed++;
      $display("FAIL bp_first_value: got %h expected 5d", d_out);
    end
    held = d_out;
    for (int i = 0; i < 10; i++) begin
      w_in_valid = i[0];
      w_a = 89'd1; w_b = 89'd2;
      @(negedge clk);
      tests_run++;
      if (w_d !== held || w_out_valid !== 1'b1 || w_in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: got d=%h valid=%b ready=%b expected d=%h valid=1 ready=0",
                 i, w_d, w_out_valid, w_in_ready, held);
      end
    end
    w_in_valid = 1'b0; w_a = 'x; w_b = 'x;
    w_out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", w_out_valid, w_in_ready);
    end
    w_xact(89'd50, 89'd60, 1'b1, d_out, lat, ok);
    tests_run++;
    if (!ok || d_out !== (90'd0 - 90'd10)) begin
      tests_failed++;
      $display("FAIL bp_next_value: got %h expected -10", d_out);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [89:0] d_out;
    int lat;
    bit ok;
    w_out_ready = 1'b1;
    w_a = 89'd1 << 70; w_b = 89'd12345; w_in_valid = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b0; w_a = 'x; w_b = 'x;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1 || w_d !== 90'd0) begin
      tests_failed++;
      $display("FAIL rst_async: got valid=%b ready=%b d=%h expected valid=0 ready=1 d=0",
               w_out_valid, w_in_ready, w_d);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      tests_run++;
      if (w_out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_no_pulse: got valid=%b expected 0", w_out_valid);
      end
    end
    w_xact(89'd5, 89'd3, 1'b1, d_out, lat, ok);
    tests_run++;
    if (!ok || d_out !== 90'd2) begin
      tests_failed++;
      $display("FAIL rst_followup: got %h expected 2", d_out);
    end
  endtask

  task automatic test_random();
    logic [95:0] ra, rb;
    logic [88:0] a, b;
    logic [89:0] d_out, exp;
    int lat;
    bit ok;
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom()};
      a = ra[88:0];
      b = rb[88:0];
      if (i % 8 == 1) b = a;
      if (i % 8 == 2) a[63:0] = '0;
      exp = {1'b0, a} - {1'b0, b};
      w_xact(a, b, 1'b1, d_out, lat, ok);
      tests_run++;
      if (!ok || d_out !== exp || lat != 3) begin
        tests_failed++;
        $display("FAIL random_%0d: got d=%h lat=%0d expected d=%h lat=3", i, d_out, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_narrow();
    test_wide();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
